gold_vc_arbiter: RTL and testbench

GOLD_VC_ARBITER -- requirements
Module: gold_vc_arbiter

---
 rtl/gold_ring_pkg.sv | 17 +
 rtl/gold_vc_arbiter_if.sv | 27 ++
 rtl/gold_rr_pick.sv | 29 ++
 rtl/gold_vc_arbiter.sv | 67 ++++++
 tb/tb_gold_vc_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gold_ring_pkg.sv
// rtl/gold_ring_pkg.sv - shared widths, VC and requester constants for the ring arbiter
package gold_ring_pkg;
   localparam int DW    = 64;
   localparam int NREQ  = 3;
   localparam int PTR_W = 2;

   localparam logic VC_EVEN = 1'b0;
   localparam logic VC_ODD  = 1'b1;

   localparam int REQ_CW  = 0;
   localparam int REQ_CCW = 1;
   localparam int REQ_PE  = 2;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int n);
      return (int'(p) + 1 >= n) ? '0 : p + 1'b1;
   endfunction
endpackage

// File: rtl/gold_vc_arbiter_if.sv
// rtl/gold_vc_arbiter_if.sv - requester/downstream bundle for the VC arbiter
interface gold_vc_arbiter_if #(
   parameter int DW   = gold_ring_pkg::DW,
   parameter int NREQ = gold_ring_pkg::NREQ
);
   import gold_ring_pkg::*;

   logic [NREQ-1:0]    req_vld;
   logic [NREQ-1:0]    req_vc;
   logic [NREQ*DW-1:0] req_data;
   logic [1:0]         out_ri;
   logic [NREQ-1:0]    grant;
   logic               out_so;
   logic [DW-1:0]      out_do;
   logic               out_vc;
   logic               polarity;

   modport master (
      output req_vld, req_vc, req_data, out_ri,
      input  grant, out_so, out_do, out_vc, polarity
   );

   modport slave (
      input  req_vld, req_vc, req_data, out_ri,
      output grant, out_so, out_do, out_vc, polarity
   );
endinterface

// File: rtl/gold_rr_pick.sv
// rtl/gold_rr_pick.sv - combinational round-robin picker starting at a pointer
module gold_rr_pick #(
   parameter int NREQ  = gold_ring_pkg::NREQ,
   parameter int PTR_W = gold_ring_pkg::PTR_W
) (
   input  logic [NREQ-1:0]  i_elig,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_onehot,
   output logic [PTR_W-1:0] o_idx
);
   import gold_ring_pkg::*;

   int w_j;

   // Scan farthest offset first so the nearest eligible slot overwrites the rest.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_j      = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_j = (int'(i_ptr) + k) % NREQ;
         if (i_elig[w_j]) begin
            o_onehot       = '0;
            o_onehot[w_j]  = 1'b1;
            o_idx          = PTR_W'(w_j);
         end
      end
   end
endmodule

// File: rtl/gold_vc_arbiter.sv
// rtl/gold_vc_arbiter.sv - two-VC alternating arbiter with per-VC round-robin pointers
module gold_vc_arbiter #(
   parameter int DW   = gold_ring_pkg::DW,
   parameter int NREQ = gold_ring_pkg::NREQ
) (
   input  logic               clk,
   input  logic               reset,
   gold_vc_arbiter_if.slave   bus
);
   import gold_ring_pkg::*;

   logic                r_pol;
   logic [PTR_W-1:0]    r_ptr [2];
   logic                r_so;
   logic [DW-1:0]       r_do;
   logic                r_vc;

   logic [NREQ-1:0]     w_vc_match;
   logic [NREQ-1:0]     w_elig;
   logic [NREQ-1:0]     w_onehot;
   logic [PTR_W-1:0]    w_idx;
   logic [PTR_W-1:0]    w_ptr;
   logic                w_any;

   assign w_vc_match = r_pol ? bus.req_vc : ~bus.req_vc;
   assign w_elig     = bus.req_vld & w_vc_match & {NREQ{bus.out_ri[r_pol] & ~reset}};
   assign w_ptr      = r_ptr[r_pol];

   gold_rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .i_elig   (w_elig),
      .i_ptr    (w_ptr),
      .o_onehot (w_onehot),
      .o_idx    (w_idx)
   );

   assign w_any        = |w_onehot;
   assign bus.grant    = w_onehot;
   assign bus.out_so   = r_so;
   assign bus.out_do   = r_do;
   assign bus.out_vc   = r_vc;
   assign bus.polarity = r_pol;

   // Only the served VC's pointer moves; the idle VC keeps its place.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pol    <= VC_EVEN;
         r_ptr[0] <= '0;
         r_ptr[1] <= '0;
         r_so     <= 1'b0;
         r_do     <= '0;
         r_vc     <= VC_EVEN;
      end else begin
         r_pol <= ~r_pol;
         if (w_any) begin
            r_ptr[r_pol] <= ptr_inc(w_idx, NREQ);
            r_so         <= 1'b1;
            r_do         <= bus.req_data[int'(w_idx)*DW +: DW];
            r_vc         <= r_pol;
         end else begin
            r_so <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_gold_vc_arbiter.sv
// tb/tb_gold_vc_arbiter.sv - directed self-checking bench for gold_vc_arbiter
module tb_gold_vc_arbiter;
   localparam int DW   = 64;
   localparam int NREQ = 3;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   gold_vc_arbiter_if #(.DW(DW), .NREQ(NREQ)) bus ();

   gold_vc_arbiter #(.DW(DW), .NREQ(NREQ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_reqs(input logic [2:0] vld, input logic [2:0] vc, input logic [1:0] ri);
      bus.req_vld = vld;
      bus.req_vc  = vc;
      bus.out_ri  = ri;
   endtask

   task automatic load_data(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2);
      bus.req_data = {d2, d1, d0};
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      set_reqs(3'b000, 3'b000, 2'b11);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load_data(64'h1, 64'h2, 64'h3);
      set_reqs(3'b111, 3'b000, 2'b11);
      @(negedge clk);
      #1;
      checks++;
      if (bus.grant !== 3'b000) begin
         failures++; $display("FAIL reset_grant: got %b want 000", bus.grant);
      end
      checks++;
      if ({bus.polarity, bus.out_so, bus.out_vc} !== 3'b000) begin
         failures++; $display("FAIL reset_flags: got pol/so/vc %b want 000", {bus.polarity, bus.out_so, bus.out_vc});
      end
      checks++;
      if (bus.out_do !== 64'h0) begin
         failures++; $display("FAIL reset_do: got %h want 0", bus.out_do);
      end
   endtask

   task automatic test_idle();
      logic exp_pol [4];
      exp_pol = '{1'b0, 1'b1, 1'b0, 1'b1};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         set_reqs(3'b000, 3'b000, 2'b11);
         #1;
         checks++;
         if (bus.polarity !== exp_pol[c] || bus.grant !== 3'b000 || bus.out_so !== 1'b0) begin
            failures++;
            $display("FAIL idle c%0d: got pol=%b grant=%b so=%b want pol=%b grant=000 so=0",
                     c, bus.polarity, bus.grant, bus.out_so, exp_pol[c]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0]  exp_g  [8];
      logic        exp_so [8];
      logic [63:0] exp_do [8];
      exp_g  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
      exp_so = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      exp_do = '{64'h0, 64'h1000, 64'h1000, 64'h1001, 64'h1001, 64'h1002, 64'h1002, 64'h1000};
      do_reset();
      load_data(64'h1000, 64'h1001, 64'h1002);
      for (int c = 0; c < 8; c++) begin
         set_reqs(3'b111, 3'b000, 2'b11);
         #1;
         checks++;
         if (bus.grant !== exp_g[c]) begin
            failures++; $display("FAIL rr_grant c%0d: got %b want %b", c, bus.grant, exp_g[c]);
         end
         checks++;
         if (bus.out_so !== exp_so[c] || bus.out_do !== exp_do[c]) begin
            failures++;
            $display("FAIL rr_out c%0d: got so=%b do=%h want so=%b do=%h", c, bus.out_so, bus.out_do, exp_so[c], exp_do[c]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_two_vc();
      do_reset();
      load_data(64'hA5, 64'h5A, 64'h0);
      set_reqs(3'b011, 3'b001, 2'b11);
      #1;
      checks++;
      if (bus.grant !== 3'b010) begin
         failures++; $display("FAIL vc_even_grant: got %b want 010", bus.grant);
      end
      @(negedge clk);
      set_reqs(3'b001, 3'b001, 2'b11);
      #1;
      checks++;
      if (bus.grant !== 3'b001 || bus.out_so !== 1'b1 || bus.out_do !== 64'h5A || bus.out_vc !== 1'b0) begin
         failures++;
         $display("FAIL vc_odd_grant: got grant=%b so=%b do=%h vc=%b want 001 1 5a 0", bus.grant, bus.out_so, bus.out_do, bus.out_vc);
      end
      @(negedge clk);
      set_reqs(3'b000, 3'b001, 2'b11);
      #1;
      checks++;
      if (bus.grant !== 3'b000 || bus.out_so !== 1'b1 || bus.out_do !== 64'hA5 || bus.out_vc !== 1'b1) begin
         failures++;
         $display("FAIL vc_odd_out: got grant=%b so=%b do=%h vc=%b want 000 1 a5 1", bus.grant, bus.out_so, bus.out_do, bus.out_vc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_so !== 1'b0 || bus.out_do !== 64'hA5 || bus.out_vc !== 1'b1) begin
         failures++;
         $display("FAIL vc_hold: got so=%b do=%h vc=%b want 0 a5 1", bus.out_so, bus.out_do, bus.out_vc);
      end
   endtask

   task automatic test_stall();
      do_reset();
      load_data(64'h2000, 64'h2001, 64'h2002);
      set_reqs(3'b111, 3'b000, 2'b11);
      #1;
      checks++;
      if (bus.grant !== 3'b001) begin
         failures++; $display("FAIL stall_pre: got %b want 001", bus.grant);
      end
      @(negedge clk);
      for (int c = 1; c <= 6; c++) begin
         set_reqs(3'b111, 3'b000, 2'b10);
         #1;
         checks++;
         if (bus.grant !== 3'b000 || (c > 1 && bus.out_so !== 1'b0)) begin
            failures++; $display("FAIL stall c%0d: got grant=%b so=%b want 000 0", c, bus.grant, bus.out_so);
         end
         @(negedge clk);
      end
      set_reqs(3'b111, 3'b000, 2'b11);
      #1;
      checks++;
      if (bus.polarity !== 1'b1 || bus.grant !== 3'b000) begin
         failures++; $display("FAIL stall_odd: got pol=%b grant=%b want 1 000", bus.polarity, bus.grant);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.grant !== 3'b010) begin
         failures++; $display("FAIL stall_resume: got %b want 010", bus.grant);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_so !== 1'b1 || bus.out_do !== 64'h2001) begin
         failures++; $display("FAIL stall_out: got so=%b do=%h want 1 2001", bus.out_so, bus.out_do);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_data(64'h3000, 64'h3001, 64'h3002);
      set_reqs(3'b111, 3'b000, 2'b11);
      @(negedge clk);
      set_reqs(3'b111, 3'b111, 2'b11);
      @(negedge clk);
      set_reqs(3'b111, 3'b000, 2'b11);
      #1;
      checks++;
      if (bus.grant !== 3'b010) begin
         failures++; $display("FAIL mid_pre_grant: got %b want 010", bus.grant);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.grant !== 3'b000) begin
         failures++; $display("FAIL mid_reset_grant: got %b want 000", bus.grant);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.out_so !== 1'b0 || bus.out_do !== 64'h0 || bus.polarity !== 1'b0) begin
         failures++;
         $display("FAIL mid_discard: got so=%b do=%h pol=%b want 0 0 0", bus.out_so, bus.out_do, bus.polarity);
      end
      checks++;
      if (bus.grant !== 3'b001) begin
         failures++; $display("FAIL mid_ptr0: got %b want 001", bus.grant);
      end
      @(negedge clk);
      set_reqs(3'b111, 3'b111, 2'b11);
      #1;
      checks++;
      if (bus.grant !== 3'b001) begin
         failures++; $display("FAIL mid_ptr1: got %b want 001", bus.grant);
      end
      @(negedge clk);
   endtask

   task automatic test_withdraw();
      logic [2:0]  exp_g  [8];
      logic [63:0] exp_do [8];
      exp_g  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
      exp_do = '{64'h0, 64'h4000, 64'h4000, 64'h4001, 64'h4001, 64'h4000, 64'h4000, 64'h4001};
      do_reset();
      load_data(64'h4000, 64'h4001, 64'h4002);
      for (int c = 0; c < 8; c++) begin
         set_reqs((c == 0) ? 3'b111 : 3'b011, 3'b000, 2'b11);
         #1;
         checks++;
         if (bus.grant !== exp_g[c] || bus.out_do !== exp_do[c]) begin
            failures++;
            $display("FAIL withdraw c%0d: got grant=%b do=%h want %b %h", c, bus.grant, bus.out_do, exp_g[c], exp_do[c]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      set_reqs(3'b000, 3'b000, 2'b00);
      load_data(64'h0, 64'h0, 64'h0);
      test_reset();
      test_idle();
      test_round_robin();
      test_two_vc();
      test_stall();
      test_reset_mid();
      test_withdraw();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
